// File: rtl/tournament_bp.sv
// Tournament conditional-branch direction predictor: gshare global table, local-history table,
// and a choice table that selects between them. The tables are swept to known values after reset.
module tournament_bp #(
    parameter int CHOICE_ENTRIES  = 1024,
    parameter int GLOBAL_ENTRIES  = 1024,
    parameter int LOCAL_ENTRIES   = 1024,
    parameter int LHT_ENTRIES     = 1024,
    parameter int CHOICE_CTR_BITS = 2,
    parameter int GLOBAL_CTR_BITS = 2,
    parameter int LOCAL_CTR_BITS  = 2,
    parameter int VLEN            = 64,
    parameter int PC_LSB          = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    output logic                                ready_o,
    input  logic                                req_valid_i,
    input  logic [VLEN-1:0]                     req_pc_i,
    output logic                                pred_valid_o,
    output logic                                pred_taken_o,
    output logic                                pred_global_o,
    input  logic                                upd_valid_i,
    input  logic [VLEN-1:0]                     upd_pc_i,
    input  logic                                upd_taken_i,
    output logic [$clog2(GLOBAL_ENTRIES)-1:0]   ghr_o
);
    localparam int CIDX = $clog2(CHOICE_ENTRIES);
    localparam int GIDX = $clog2(GLOBAL_ENTRIES);
    localparam int LIDX = $clog2(LOCAL_ENTRIES);
    localparam int HIDX = $clog2(LHT_ENTRIES);
    localparam int CB   = CHOICE_CTR_BITS;
    localparam int GB   = GLOBAL_CTR_BITS;
    localparam int LB   = LOCAL_CTR_BITS;
    localparam int MAX_A       = (CHOICE_ENTRIES > GLOBAL_ENTRIES) ? CHOICE_ENTRIES : GLOBAL_ENTRIES;
    localparam int MAX_B       = (LOCAL_ENTRIES > LHT_ENTRIES) ? LOCAL_ENTRIES : LHT_ENTRIES;
    localparam int MAX_ENTRIES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int SW          = $clog2(MAX_ENTRIES) + 1;

    localparam logic [CB-1:0] C_INIT = {1'b0, {(CB-1){1'b1}}};
    localparam logic [GB-1:0] G_INIT = {1'b0, {(GB-1){1'b1}}};
    localparam logic [LB-1:0] L_INIT = {1'b0, {(LB-1){1'b1}}};
    localparam logic [CB-1:0] C_TOP  = {CB{1'b1}};
    localparam logic [GB-1:0] G_TOP  = {GB{1'b1}};
    localparam logic [LB-1:0] L_TOP  = {LB{1'b1}};

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [SW-1:0]   r_idx;
    logic [SW-1:0]   w_idx_next;
    logic            r_ready;
    logic [GIDX-1:0] r_ghr;
    logic            r_pred_valid;
    logic            r_pred_taken;
    logic            r_pred_global;

    logic [CB-1:0]   r_choice [CHOICE_ENTRIES];
    logic [GB-1:0]   r_global [GLOBAL_ENTRIES];
    logic [LB-1:0]   r_local  [LOCAL_ENTRIES];
    logic [LIDX-1:0] r_lht    [LHT_ENTRIES];

    logic            w_sweep, w_sweep_c, w_sweep_g, w_sweep_l, w_sweep_h;
    logic            w_req_en, w_upd_en;
    logic [CIDX-1:0] w_req_cidx, w_upd_cidx;
    logic [GIDX-1:0] w_req_gidx, w_upd_gidx;
    logic [HIDX-1:0] w_req_hidx, w_upd_hidx;
    logic [LIDX-1:0] w_req_lidx, w_upd_lidx;
    logic [CB-1:0]   w_req_c, w_upd_c, w_c_next;
    logic [GB-1:0]   w_req_g, w_upd_g, w_g_next;
    logic [LB-1:0]   w_req_l, w_upd_l, w_l_next;
    logic            w_c_change;
    logic            w_unused;

    assign w_unused = ^{req_pc_i, upd_pc_i};

    assign w_sweep   = (r_state == ST_INIT) && (32'(r_idx) < MAX_ENTRIES);
    assign w_sweep_c = w_sweep && (32'(r_idx) < CHOICE_ENTRIES);
    assign w_sweep_g = w_sweep && (32'(r_idx) < GLOBAL_ENTRIES);
    assign w_sweep_l = w_sweep && (32'(r_idx) < LOCAL_ENTRIES);
    assign w_sweep_h = w_sweep && (32'(r_idx) < LHT_ENTRIES);

    assign w_req_en   = req_valid_i & r_ready;
    assign w_upd_en   = upd_valid_i & r_ready;

    assign w_req_cidx = req_pc_i[PC_LSB +: CIDX];
    assign w_req_hidx = req_pc_i[PC_LSB +: HIDX];
    assign w_req_gidx = req_pc_i[PC_LSB +: GIDX] ^ r_ghr;
    assign w_req_lidx = r_lht[w_req_hidx];
    assign w_req_c    = r_choice[w_req_cidx];
    assign w_req_g    = r_global[w_req_gidx];
    assign w_req_l    = r_local[w_req_lidx];

    assign w_upd_cidx = upd_pc_i[PC_LSB +: CIDX];
    assign w_upd_hidx = upd_pc_i[PC_LSB +: HIDX];
    assign w_upd_gidx = upd_pc_i[PC_LSB +: GIDX] ^ r_ghr;
    assign w_upd_lidx = r_lht[w_upd_hidx];
    assign w_upd_c    = r_choice[w_upd_cidx];
    assign w_upd_g    = r_global[w_upd_gidx];
    assign w_upd_l    = r_local[w_upd_lidx];

    // The choice counter only learns when the two components disagree.
    assign w_c_change = w_upd_g[GB-1] != w_upd_l[LB-1];

    // Next-state logic: sweep all entries, then one extra edge to enter READY.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_INIT: begin
                if (32'(r_idx) == MAX_ENTRIES) begin
                    w_state_next = ST_READY;
                end else begin
                    w_idx_next = r_idx + SW'(1);
                end
            end
            ST_READY: w_state_next = ST_READY;
            default:  w_state_next = ST_INIT;
        endcase
    end

    // Saturating next values of the counters addressed by the update.
    always_comb begin
        w_g_next = w_upd_g;
        w_l_next = w_upd_l;
        w_c_next = w_upd_c;
        if (upd_taken_i) begin
            w_g_next = (w_upd_g == G_TOP) ? w_upd_g : w_upd_g + GB'(1);
            w_l_next = (w_upd_l == L_TOP) ? w_upd_l : w_upd_l + LB'(1);
        end else begin
            w_g_next = (w_upd_g == {GB{1'b0}}) ? w_upd_g : w_upd_g - GB'(1);
            w_l_next = (w_upd_l == {LB{1'b0}}) ? w_upd_l : w_upd_l - LB'(1);
        end
        if (w_upd_g[GB-1] == upd_taken_i) begin
            w_c_next = (w_upd_c == C_TOP) ? w_upd_c : w_upd_c + CB'(1);
        end else begin
            w_c_next = (w_upd_c == {CB{1'b0}}) ? w_upd_c : w_upd_c - CB'(1);
        end
    end

    // FSM state, sweep index and ready flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_INIT;
            r_idx   <= {SW{1'b0}};
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_ready <= (w_state_next == ST_READY);
        end
    end

    // Registered prediction and global history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_global <= 1'b0;
            r_ghr         <= {GIDX{1'b0}};
        end else begin
            r_pred_valid <= w_req_en;
            if (w_req_en) begin
                r_pred_global <= w_req_c[CB-1];
                r_pred_taken  <= w_req_c[CB-1] ? w_req_g[GB-1] : w_req_l[LB-1];
            end
            if (w_upd_en) begin
                r_ghr <= {r_ghr[GIDX-2:0], upd_taken_i};
            end
        end
    end

    // Table storage has no reset; the INIT sweep establishes its contents.
    always_ff @(posedge clk_i) begin
        if (w_sweep_c) begin
            r_choice[r_idx[CIDX-1:0]] <= C_INIT;
        end else if (w_upd_en && w_c_change) begin
            r_choice[w_upd_cidx] <= w_c_next;
        end
        if (w_sweep_g) begin
            r_global[r_idx[GIDX-1:0]] <= G_INIT;
        end else if (w_upd_en) begin
            r_global[w_upd_gidx] <= w_g_next;
        end
        if (w_sweep_l) begin
            r_local[r_idx[LIDX-1:0]] <= L_INIT;
        end else if (w_upd_en) begin
            r_local[w_upd_lidx] <= w_l_next;
        end
        if (w_sweep_h) begin
            r_lht[r_idx[HIDX-1:0]] <= {LIDX{1'b0}};
        end else if (w_upd_en) begin
            r_lht[w_upd_hidx] <= {w_upd_lidx[LIDX-2:0], upd_taken_i};
        end
    end

    assign ready_o       = r_ready;
    assign pred_valid_o  = r_pred_valid;
    assign pred_taken_o  = r_pred_taken;
    assign pred_global_o = r_pred_global;
    assign ghr_o         = r_ghr;

endmodule

// File: tb/tb_tournament_bp.sv
// Self-checking bench for tournament_bp with 16-entry tables and 2-bit counters;
// a behavioural predictor model feeds a queue of expected predictions.
module tb_tournament_bp;
    localparam int VLEN = 64;

    typedef struct packed {
        logic taken;
        logic glob;
    } pred_t;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            ready_o;
    logic            req_valid_i = 1'b0;
    logic [VLEN-1:0] req_pc_i = 64'h0;
    logic            pred_valid_o, pred_taken_o, pred_global_o;
    logic            upd_valid_i = 1'b0;
    logic [VLEN-1:0] upd_pc_i = 64'h0;
    logic            upd_taken_i = 1'b0;
    logic [3:0]      ghr_o;

    int    errors = 0;
    int    checks = 0;
    pred_t exp_q[$];
    pred_t got;

    logic [1:0] m_ch  [16];
    logic [1:0] m_gl  [16];
    logic [1:0] m_lo  [16];
    logic [3:0] m_lht [16];
    logic [3:0] m_ghr;
    logic       model_ready = 1'b0;

    tournament_bp #(
        .CHOICE_ENTRIES(16), .GLOBAL_ENTRIES(16), .LOCAL_ENTRIES(16), .LHT_ENTRIES(16),
        .CHOICE_CTR_BITS(2), .GLOBAL_CTR_BITS(2), .LOCAL_CTR_BITS(2),
        .VLEN(VLEN), .PC_LSB(1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ready_o(ready_o),
        .req_valid_i(req_valid_i), .req_pc_i(req_pc_i),
        .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_global_o(pred_global_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .ghr_o(ghr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_ch[i]  = 2'b01;
            m_gl[i]  = 2'b01;
            m_lo[i]  = 2'b01;
            m_lht[i] = 4'b0000;
        end
        m_ghr = 4'b0000;
        exp_q.delete();
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    function automatic pred_t model_predict(input logic [VLEN-1:0] pc);
        pred_t p;
        logic [3:0] idx;
        idx    = pc[4:1];
        p.glob = m_ch[idx][1];
        p.taken = p.glob ? m_gl[idx ^ m_ghr][1] : m_lo[m_lht[idx]][1];
        return p;
    endfunction

    task automatic model_update(input logic [VLEN-1:0] pc, input logic t);
        logic [3:0] idx, g, l;
        logic gm, lm;
        idx = pc[4:1];
        g   = idx ^ m_ghr;
        l   = m_lht[idx];
        gm  = m_gl[g][1];
        lm  = m_lo[l][1];
        m_gl[g] = sat(m_gl[g], t);
        m_lo[l] = sat(m_lo[l], t);
        if (gm != lm) m_ch[idx] = sat(m_ch[idx], gm == t);
        m_lht[idx] = {l[2:0], t};
        m_ghr      = {m_ghr[2:0], t};
    endtask

    // One clock of stimulus; the model sees the same request/update with read-before-write.
    task automatic step(input logic rv, input logic [VLEN-1:0] rpc,
                        input logic uv, input logic [VLEN-1:0] upc, input logic ut);
        req_valid_i = rv;
        req_pc_i    = rpc;
        upd_valid_i = uv;
        upd_pc_i    = upc;
        upd_taken_i = ut;
        if (rv && model_ready) exp_q.push_back(model_predict(rpc));
        if (uv && model_ready) model_update(upc, ut);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        upd_valid_i = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int edges;
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i);
            #1;
            if (ready_o === 1'b1) begin
                edges = k;
                break;
            end
        end
        checks++;
        if (edges != 17) begin
            errors++;
            $display("FAIL %s: ready after %0d edges, required 17", name, edges);
        end
        model_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if ({ready_o, pred_valid_o, pred_taken_o, pred_global_o, ghr_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: got %b required 00000000",
                     {ready_o, pred_valid_o, pred_taken_o, pred_global_o, ghr_o});
        end
        rst_i = 1'b0;
        model_reset();
        model_ready = 1'b0;
        wait_ready("init_latency");
        step(1'b1, 64'h8000_0000, 1'b0, 64'h0, 1'b0);
        checks++;
        if ({pred_valid_o, pred_taken_o, pred_global_o} !== 3'b100) begin
            errors++;
            $display("FAIL first_lookup: got %b required 100", {pred_valid_o, pred_taken_o, pred_global_o});
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic test_ghr();
        step(1'b0, 64'h0, 1'b1, 64'h100, 1'b1);
        step(1'b0, 64'h0, 1'b1, 64'h100, 1'b1);
        step(1'b0, 64'h0, 1'b1, 64'h100, 1'b0);
        checks++;
        if (ghr_o !== 4'b0110) begin
            errors++;
            $display("FAIL ghr_ttn: got %b required 0110", ghr_o);
        end
    endtask

    task automatic train_0x200();
        for (int k = 0; k < 20; k++) step(1'b0, 64'h0, 1'b1, 64'h200, 1'b1);
    endtask

    task automatic test_saturation();
        train_0x200();
        step(1'b1, 64'h200, 1'b0, 64'h0, 1'b0);
        got = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b00;
        checks++;
        if (pred_valid_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_taken_o !== got.taken) begin
            errors++;
            $display("FAIL trained_taken: got v=%b t=%b required v=1 t=1 (model %b)",
                     pred_valid_o, pred_taken_o, got.taken);
        end
        step(1'b0, 64'h0, 1'b1, 64'h200, 1'b0);
        for (int k = 0; k < 19; k++) step(1'b0, 64'h0, 1'b1, 64'h200, 1'b1);
        step(1'b1, 64'h200, 1'b0, 64'h0, 1'b0);
        got = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b00;
        checks++;
        if (pred_taken_o !== 1'b1 || pred_taken_o !== got.taken || pred_global_o !== got.glob) begin
            errors++;
            $display("FAIL saturated_taken: got t=%b g=%b required t=1 g=%b",
                     pred_taken_o, pred_global_o, got.glob);
        end
    endtask

    task automatic test_init_ignore();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        model_ready = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step(1'b1, 64'h40, 1'b1, 64'h40, 1'b1);
            checks++;
            if (ghr_o !== 4'b0000 || pred_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL init_ignore cycle %0d: ghr=%b valid=%b required 0000/0", k, ghr_o, pred_valid_o);
            end
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL init_ready: got %b required 1", ready_o);
        end
        model_ready = 1'b1;
    endtask

    task automatic test_same_cycle();
        step(1'b1, 64'h40, 1'b1, 64'h40, 1'b1);
        got = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b11;
        checks++;
        if (pred_valid_o !== 1'b1 || pred_taken_o !== 1'b0 || pred_taken_o !== got.taken) begin
            errors++;
            $display("FAIL same_cycle_pred: got v=%b t=%b required v=1 t=0", pred_valid_o, pred_taken_o);
        end
        checks++;
        if (ghr_o !== 4'b0001) begin
            errors++;
            $display("FAIL same_cycle_ghr: got %b required 0001", ghr_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [VLEN-1:0] rpc, upc;
        logic uv, ut;
        for (int k = 0; k < 60; k++) begin
            rpc = 64'($urandom_range(0, 31)) << 1;
            upc = 64'($urandom_range(0, 31)) << 1;
            uv  = ($urandom_range(0, 3) != 0);
            ut  = ($urandom_range(0, 2) != 0);
            step(1'b1, rpc, uv, upc, ut);
            checks++;
            if (pred_valid_o !== 1'b1 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL b2b_valid %0d: valid=%b queued=%0d required 1/>0", k, pred_valid_o, exp_q.size());
            end else begin
                got = exp_q.pop_front();
                if ({pred_taken_o, pred_global_o} !== {got.taken, got.glob}) begin
                    errors++;
                    $display("FAIL b2b_pred %0d: got t=%b g=%b required t=%b g=%b",
                             k, pred_taken_o, pred_global_o, got.taken, got.glob);
                end
            end
            checks++;
            if (ghr_o !== m_ghr) begin
                errors++;
                $display("FAIL b2b_ghr %0d: got %b required %b", k, ghr_o, m_ghr);
            end
        end
    endtask

    task automatic test_reset_mid();
        train_0x200();
        rst_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0 || ghr_o !== 4'b0000 || pred_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: ready=%b ghr=%b valid=%b required 0/0000/0", ready_o, ghr_o, pred_valid_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        model_ready = 1'b0;
        wait_ready("reinit_latency");
        step(1'b1, 64'h200, 1'b0, 64'h0, 1'b0);
        got = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b11;
        checks++;
        if (pred_valid_o !== 1'b1 || pred_taken_o !== 1'b0 || pred_taken_o !== got.taken) begin
            errors++;
            $display("FAIL reset_mid_pred: got v=%b t=%b required v=1 t=0", pred_valid_o, pred_taken_o);
        end
    endtask

    initial begin
        test_reset();
        test_ghr();
        test_saturation();
        test_init_ignore();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tournament_bp.md
# tournament_bp

Tournament (local/global/choice) conditional-branch direction predictor for the CVA6 frontend. It is sized by the branch-predictor fields of the core configuration: BranchPredictorImpl, ChoicePredictorSize, GlobalPredictorSize, LocalPredictorSize, LocalHistoryTableSize and the per-table counter widths. It sits beside the BTB and RAS, upstream of the frontend's next-PC selection, and delivers a registered taken/not-taken prediction one cycle after a lookup. Tables are trained non-speculatively from resolved branches.

## Interface
- CHOICE_ENTRIES, 1024: choice counter table depth (power of 2), CIDX = log2.
- GLOBAL_ENTRIES, 1024: gshare counter table depth (power of 2); GIDX = log2 = GHR width.
- LOCAL_ENTRIES, 1024: local counter table depth (power of 2); LIDX = log2 = local history width.
- LHT_ENTRIES, 1024: local history table depth (power of 2), HIDX = log2.
- CHOICE_CTR_BITS / GLOBAL_CTR_BITS / LOCAL_CTR_BITS, 2: saturating counter widths, each ≥ 2.
- VLEN, 64: PC width.
- PC_LSB, 1: lowest PC bit used for indexing (bit 0 dropped for RVC).
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ready_o  out  1  table initialisation complete; lookups/updates accepted.
- req_valid_i  in  1  lookup request.
- req_pc_i  in  VLEN  lookup PC.
- pred_valid_o  out  1  prediction valid (registered).
- pred_taken_o  out  1  predicted direction.
- pred_global_o  out  1  1 = global component chosen, 0 = local.
- upd_valid_i  in  1  resolved conditional branch.
- upd_pc_i  in  VLEN  resolved branch PC.
- upd_taken_i  in  1  actual outcome.
- ghr_o  out  GIDX  current global history register (observability).

## Operation
- Indices: cidx = pc[PC_LSB +: CIDX]; hidx = pc[PC_LSB +: HIDX]; gidx = pc[PC_LSB +: GIDX] ^ ghr; lidx = lht[hidx].
- Counter MSB = 1 means taken. Choice MSB = 1 means use global.
- Prediction = choice MSB ? global[gidx] MSB : local[lidx] MSB.
- State machine has two states, INIT and READY.
- INIT: a sweep counter i runs 0..MAX-1, where MAX = max of the four depths. Each cycle it writes entry i of every table with i < depth:
  - global and local counters get 2^(CTR_BITS-1)-1 (weakly not-taken);
  - choice counters get 2^(CTR_BITS-1)-1 (weakly prefer local);
  - LHT entries get 0.
- INIT → READY after entry MAX-1 is written. ready_o = 1 from the next cycle.
- req_valid_i and upd_valid_i are ignored in INIT.
- Update, READY and upd_valid_i, all in one cycle, with indices computed from upd_pc_i and the current ghr/lht:
  - global[gidx] and local[lidx] saturating ±1 toward upd_taken_i (no wrap past 0 or all-ones);
  - choice[cidx] changes only when the global and local MSBs differ: +1 if the global MSB == upd_taken_i, else −1, saturating;
  - lht[hidx] <= {lht[hidx][LIDX-2:0], upd_taken_i};
  - ghr <= {ghr[GIDX-2:0], upd_taken_i}.
- Simultaneous lookup and update, including to the same PC or index: the lookup sees pre-update state (read-before-write). Both actions take effect.
- Reset mid-operation: all outputs drop to their reset values immediately, ghr clears, and the FSM re-enters INIT with i = 0.

## Timing
- Reset values: ready_o 0, pred_valid_o 0, pred_taken_o 0, pred_global_o 0, ghr_o 0, FSM INIT, i 0.
- Init latency: ready_o rises exactly MAX+1 rising edges after rst_i deasserts (MAX sweep writes plus 1 state-transition edge).
- Lookup latency: request in cycle N (READY) gives pred_valid_o/pred_taken_o/pred_global_o in cycle N+1.
- pred_valid_o = registered (req_valid_i & ready_o). The other prediction outputs hold their last value when pred_valid_o = 0.
- An update in cycle N is visible to lookups issued in cycle N+1. ghr_o changes in cycle N+1.
- No backpressure. One lookup and one update per cycle are always accepted in READY.

## Test plan
- Bench parameters: all depths 16, all counter widths 2.
1. Release reset and count cycles: ready_o = 1 at the 17th rising edge after deassert. A lookup at PC 0x8000_0000 then returns pred_valid_o = 1, pred_taken_o = 0, pred_global_o = 0.
2. Updates T, T, N at PC 0x100, issued in READY → ghr_o = 4'b0110.
3. 20 taken updates at PC 0x200, then a lookup at 0x200 → pred_taken_o = 1. One not-taken update followed by 19 taken updates (history restored), then a lookup → still pred_taken_o = 1 (counter saturation).
4. Lookup and taken update at PC 0x40 in the same cycle, first cycle of READY → prediction pred_taken_o = 0 (pre-update state); ghr_o = 4'b0001 in the next cycle.
5. upd_valid_i = 1 with taken on every cycle during INIT → ghr_o stays 0 and pred_valid_o stays 0 throughout INIT.
6. Train as in case 3, then pulse rst_i for 1 cycle → ready_o and ghr_o are 0 immediately. After a 17-cycle re-sweep, a lookup at 0x200 returns pred_taken_o = 0.
